// File: rtl/slide_text_scroller_if.sv
// Bundled control, write-port and display signals for slide_text_scroller.
// The master side drives the requests and text writes; the slave side is the scroller.
interface slide_text_scroller_if #(
    parameter int MSG_LEN = 16,
    parameter int DIGITS  = 4,
    parameter int CHAR_W  = 8
);
    localparam int AW = $clog2(MSG_LEN);
    localparam int LW = AW + 1;

    logic                     i_tick_slide;
    logic                     i_start;
    logic                     i_stop;
    logic                     i_dir;
    logic [LW-1:0]            i_len_cfg;
    logic                     i_wr_en;
    logic [AW-1:0]            i_wr_addr;
    logic [CHAR_W-1:0]        i_wr_data;
    logic [DIGITS*CHAR_W-1:0] o_window;
    logic [AW-1:0]            o_offset;
    logic                     o_busy;
    logic                     o_wrap_pulse;

    modport master (
        output i_tick_slide, i_start, i_stop, i_dir, i_len_cfg,
        output i_wr_en, i_wr_addr, i_wr_data,
        input  o_window, o_offset, o_busy, o_wrap_pulse
    );

    modport slave (
        input  i_tick_slide, i_start, i_stop, i_dir, i_len_cfg,
        input  i_wr_en, i_wr_addr, i_wr_data,
        output o_window, o_offset, o_busy, o_wrap_pulse
    );
endinterface

// File: rtl/slide_text_scroller.sv
// Circular message buffer scrolled one character per slide tick, with a registered DIGITS-wide window.
// Define SLIDE_BOUNCE_EN for ping-pong scrolling instead of circular wrap.
module slide_text_scroller #(
    parameter int                MSG_LEN = 16,
    parameter int                DIGITS  = 4,
    parameter int                CHAR_W  = 8,
    parameter logic [CHAR_W-1:0] BLANK   = 8'h20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    slide_text_scroller_if.slave bus
);
    localparam int AW = $clog2(MSG_LEN);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LEN_MAX = LW'(MSG_LEN);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [LW-1:0]            r_len;
    logic [LW-1:0]            w_len_nxt;
    logic [LW-1:0]            w_len_clamp;
    logic [AW-1:0]            r_offset;
    logic [AW-1:0]            w_offset_nxt;
    logic                     r_wrap;
    logic                     w_wrap_nxt;
    logic [CHAR_W-1:0]        r_buf [MSG_LEN];
    logic [DIGITS*CHAR_W-1:0] r_window;
    logic [DIGITS*CHAR_W-1:0] w_window;
    logic [LW-1:0]            w_idx;
`ifdef SLIDE_BOUNCE_EN
    localparam logic [LW-1:0] DIG_L = LW'(DIGITS);
    logic                     r_dir;
    logic                     w_dir_nxt;
    logic [LW-1:0]            w_span;
    assign w_span = r_len - DIG_L;
`else
    logic [LW-1:0]            w_len_m1;
    assign w_len_m1 = r_len - {{(LW-1){1'b0}}, 1'b1};
`endif

    assign w_len_clamp = ((bus.i_len_cfg == {LW{1'b0}}) || (bus.i_len_cfg > LEN_MAX))
                         ? LEN_MAX : bus.i_len_cfg;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: stop outranks start
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!bus.i_stop && bus.i_start) w_state_nxt = ST_RUN;
                else                            w_state_nxt = ST_IDLE;
            end
            ST_RUN: begin
                if (bus.i_stop) w_state_nxt = ST_IDLE;
                else            w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output/datapath next values: length capture on start, offset stepping on tick
    always_comb begin
        w_len_nxt    = r_len;
        w_offset_nxt = r_offset;
        w_wrap_nxt   = 1'b0;
`ifdef SLIDE_BOUNCE_EN
        w_dir_nxt    = r_dir;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!bus.i_stop && bus.i_start) begin
                    w_len_nxt = w_len_clamp;
`ifdef SLIDE_BOUNCE_EN
                    w_dir_nxt = bus.i_dir;
                    if ((w_len_clamp <= DIG_L) || ({1'b0, r_offset} > (w_len_clamp - DIG_L)))
                        w_offset_nxt = {AW{1'b0}};
                    else
                        w_offset_nxt = r_offset;
`else
                    if ({1'b0, r_offset} >= w_len_clamp) w_offset_nxt = {AW{1'b0}};
                    else                                 w_offset_nxt = r_offset;
`endif
                end else begin
                    w_len_nxt = r_len;
                end
            end
            ST_RUN: begin
                if (!bus.i_stop && bus.i_tick_slide) begin
`ifdef SLIDE_BOUNCE_EN
                    // A reversal steps one position back toward the interior
                    if (r_len <= DIG_L) begin
                        w_offset_nxt = {AW{1'b0}};
                    end else if (!r_dir) begin
                        if ({1'b0, r_offset} >= w_span) begin
                            w_offset_nxt = r_offset - {{(AW-1){1'b0}}, 1'b1};
                            w_dir_nxt    = 1'b1;
                            w_wrap_nxt   = 1'b1;
                        end else begin
                            w_offset_nxt = r_offset + {{(AW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        if (r_offset == {AW{1'b0}}) begin
                            w_offset_nxt = r_offset + {{(AW-1){1'b0}}, 1'b1};
                            w_dir_nxt    = 1'b0;
                            w_wrap_nxt   = 1'b1;
                        end else begin
                            w_offset_nxt = r_offset - {{(AW-1){1'b0}}, 1'b1};
                        end
                    end
`else
                    if (!bus.i_dir) begin
                        if ({1'b0, r_offset} == w_len_m1) begin
                            w_offset_nxt = {AW{1'b0}};
                            w_wrap_nxt   = 1'b1;
                        end else begin
                            w_offset_nxt = r_offset + {{(AW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        if (r_offset == {AW{1'b0}}) begin
                            w_offset_nxt = w_len_m1[AW-1:0];
                            w_wrap_nxt   = 1'b1;
                        end else begin
                            w_offset_nxt = r_offset - {{(AW-1){1'b0}}, 1'b1};
                        end
                    end
`endif
                end else begin
                    w_offset_nxt = r_offset;
                end
            end
            default: begin
                w_offset_nxt = {AW{1'b0}};
            end
        endcase
    end

    // Control/datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len    <= LEN_MAX;
            r_offset <= {AW{1'b0}};
            r_wrap   <= 1'b0;
`ifdef SLIDE_BOUNCE_EN
            r_dir    <= 1'b0;
`endif
        end else begin
            r_len    <= w_len_nxt;
            r_offset <= w_offset_nxt;
            r_wrap   <= w_wrap_nxt;
`ifdef SLIDE_BOUNCE_EN
            r_dir    <= w_dir_nxt;
`endif
        end
    end

    // Window gather: walk indices from offset, folding back to 0 at len (tiles when len < DIGITS)
    always_comb begin
        w_window = {(DIGITS*CHAR_W){1'b0}};
        w_idx    = {1'b0, r_offset};
        for (int k = 0; k < DIGITS; k++) begin
            w_window[(DIGITS-1-k)*CHAR_W +: CHAR_W] = r_buf[w_idx[AW-1:0]];
            if ((w_idx + {{(LW-1){1'b0}}, 1'b1}) >= r_len) w_idx = {LW{1'b0}};
            else                                          w_idx = w_idx + {{(LW-1){1'b0}}, 1'b1};
        end
    end

    // Message buffer write port and registered window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_LEN; i++) r_buf[i] <= BLANK;
            r_window <= {DIGITS{BLANK}};
        end else begin
            if (bus.i_wr_en && ({1'b0, bus.i_wr_addr} < LEN_MAX)) begin
                r_buf[bus.i_wr_addr] <= bus.i_wr_data;
            end
            r_window <= w_window;
        end
    end

    assign bus.o_window     = r_window;
    assign bus.o_offset     = r_offset;
    assign bus.o_busy       = (r_state == ST_RUN);
    assign bus.o_wrap_pulse = r_wrap;
endmodule

// File: tb/tb_slide_text_scroller.sv
// Directed bench for slide_text_scroller: an arithmetic reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_slide_text_scroller;
    localparam int ML = 16;
    localparam int D  = 4;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   chk_on = 1'b0;

    slide_text_scroller_if #(.MSG_LEN(ML), .DIGITS(D), .CHAR_W(8)) bus ();

    slide_text_scroller #(.MSG_LEN(ML), .DIGITS(D), .CHAR_W(8), .BLANK(8'h20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model state
    bit         m_run;
    int         m_len;
    int         m_off;
    bit         m_wrap;
    bit         m_dir;
    logic [7:0] m_buf [ML];
    logic [31:0] m_win;

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] nw;
        int          nxt;
        if (!rst_n) begin
            m_run = 1'b0; m_len = ML; m_off = 0; m_wrap = 1'b0; m_dir = 1'b0;
            for (int i = 0; i < ML; i++) m_buf[i] = 8'h20;
            m_win = 32'h20202020;
        end else begin
            for (int k = 0; k < D; k++) nw[(D-1-k)*8 +: 8] = m_buf[(m_off + k) % m_len];
            if (bus.i_wr_en && int'(bus.i_wr_addr) < ML) m_buf[bus.i_wr_addr] = bus.i_wr_data;
            m_wrap = 1'b0;
            if (m_run) begin
                if (bus.i_stop) m_run = 1'b0;
                else if (bus.i_tick_slide) begin
`ifdef SLIDE_BOUNCE_EN
                    if (m_len <= D) m_off = 0;
                    else begin
                        nxt = m_dir ? m_off - 1 : m_off + 1;
                        if (nxt < 0 || nxt > m_len - D) begin
                            m_dir  = !m_dir;
                            nxt    = m_dir ? m_off - 1 : m_off + 1;
                            m_wrap = 1'b1;
                        end
                        m_off = nxt;
                    end
`else
                    if (!bus.i_dir) begin
                        m_off  = (m_off + 1) % m_len;
                        m_wrap = (m_off == 0);
                    end else begin
                        m_wrap = (m_off == 0);
                        m_off  = (m_off + m_len - 1) % m_len;
                    end
`endif
                end
            end else if (bus.i_start && !bus.i_stop) begin
                m_run = 1'b1;
                m_len = (bus.i_len_cfg == 0 || int'(bus.i_len_cfg) > ML) ? ML : int'(bus.i_len_cfg);
                if (m_off >= m_len) m_off = 0;
`ifdef SLIDE_BOUNCE_EN
                m_dir = bus.i_dir;
                if (m_len <= D || m_off > m_len - D) m_off = 0;
`endif
            end
            m_win = nw;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_offset", 32'(bus.o_offset), 32'(m_off));
            chk("model_busy",   32'(bus.o_busy),   32'(m_run));
            chk("model_wrap",   32'(bus.o_wrap_pulse), 32'(m_wrap));
            chk("model_window", bus.o_window, m_win);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic tick_once();
        bus.i_tick_slide = 1'b1;
        cyc();
        bus.i_tick_slide = 1'b0;
    endtask

    task automatic wr(input int addr, input logic [7:0] data);
        bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'(addr); bus.i_wr_data = data;
        cyc();
        bus.i_wr_en = 1'b0;
    endtask

    task automatic start_run(input int len, input bit d);
        bus.i_len_cfg = 5'(len); bus.i_dir = d; bus.i_start = 1'b1;
        cyc();
        bus.i_start = 1'b0;
    endtask

    logic [39:0] hello;
    logic [47:0] abc;

    initial begin
        bus.i_tick_slide = 1'b0; bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_dir = 1'b0;
        bus.i_len_cfg = 5'd0; bus.i_wr_en = 1'b0; bus.i_wr_addr = 4'd0; bus.i_wr_data = 8'h00;
        hello = "HELLO";
        abc   = "ABCDEF";
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        chk_on = 1'b1;
        repeat (3) cyc();
        chk("rst_window", bus.o_window, 32'h20202020);
        chk("rst_offset", 32'(bus.o_offset), 32'd0);
        chk("rst_busy",   32'(bus.o_busy), 32'd0);
        chk("rst_wrap",   32'(bus.o_wrap_pulse), 32'd0);
        rst_n = 1'b1;
        repeat (2) cyc();
        chk("post_rst_window", bus.o_window, 32'h20202020);

`ifdef SLIDE_BOUNCE_EN
        for (int i = 0; i < 6; i++) wr(i, abc[8*(5-i) +: 8]);
        start_run(6, 1'b0);
        begin
            int exp_off [6] = '{1, 2, 1, 0, 1, 2};
            for (int t = 0; t < 6; t++) begin
                tick_once();
                chk("bounce_offset", 32'(bus.o_offset), 32'(exp_off[t]));
                chk("bounce_wrap", 32'(bus.o_wrap_pulse), (t == 2 || t == 4) ? 32'd1 : 32'd0);
                cyc();
            end
        end
        chk("bounce_window", bus.o_window, 32'h43444546);
`else
        for (int i = 0; i < 5; i++) wr(i, hello[8*(4-i) +: 8]);
        start_run(5, 1'b0);
        chk("start_busy", 32'(bus.o_busy), 32'd1);
        chk("start_offset", 32'(bus.o_offset), 32'd0);
        cyc();
        chk("hell_window", bus.o_window, 32'h48454C4C);
        begin
            int exp_off [5] = '{1, 2, 3, 4, 0};
            for (int t = 0; t < 5; t++) begin
                tick_once();
                chk("left_offset", 32'(bus.o_offset), 32'(exp_off[t]));
                chk("left_wrap", 32'(bus.o_wrap_pulse), (t == 4) ? 32'd1 : 32'd0);
                cyc();
                if (t == 0) chk("ello_window", bus.o_window, 32'h454C4C4F);
            end
        end
        // scroll right across the zero boundary
        bus.i_dir = 1'b1;
        tick_once();
        chk("right_offset", 32'(bus.o_offset), 32'd4);
        chk("right_wrap", 32'(bus.o_wrap_pulse), 32'd1);
        cyc();
        chk("ohel_window", bus.o_window, 32'h4F48454C);
        chk("right_wrap_clear", 32'(bus.o_wrap_pulse), 32'd0);
        tick_once();
        tick_once();
        chk("to2_offset", 32'(bus.o_offset), 32'd2);
        // stop beats a simultaneous tick
        bus.i_stop = 1'b1; bus.i_tick_slide = 1'b1;
        cyc();
        bus.i_stop = 1'b0; bus.i_tick_slide = 1'b0;
        chk("stop_busy", 32'(bus.o_busy), 32'd0);
        chk("stop_offset", 32'(bus.o_offset), 32'd2);
        tick_once();
        chk("idle_tick_offset", 32'(bus.o_offset), 32'd2);
        start_run(2, 1'b0);
        chk("restart_offset", 32'(bus.o_offset), 32'd0);
        chk("restart_busy", 32'(bus.o_busy), 32'd1);
        cyc();
        chk("tile_window", bus.o_window, 32'h48454845);
        wr(1, 8'h5A);
        chk("wr_one_edge", bus.o_window, 32'h48454845);
        cyc();
        chk("wr_two_edges", bus.o_window, 32'h485A485A);
        // mixed traffic checked by the model
        tick_once();
        bus.i_tick_slide = 1'b1; bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'd0; bus.i_wr_data = 8'h51;
        cyc();
        bus.i_tick_slide = 1'b0; bus.i_wr_en = 1'b0;
        start_run(7, 1'b0);
        repeat (3) tick_once();
        bus.i_stop = 1'b1; cyc(); bus.i_stop = 1'b0;
        start_run(0, 1'b1);
        repeat (3) tick_once();
        start_run(9, 1'b0);
        repeat (2) cyc();
        // asynchronous reset in the middle of a run
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_offset", 32'(bus.o_offset), 32'd0);
        chk("midrst_busy", 32'(bus.o_busy), 32'd0);
        chk("midrst_window", bus.o_window, 32'h20202020);
        cyc();
        rst_n = 1'b1;
        repeat (2) cyc();
        chk("post_midrst_window", bus.o_window, 32'h20202020);
`endif
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
